mdu_e: RTL and testbench
========================

Name: mdu_e

Overview:
- Execute-stage multiply/divide unit; runs alongside the ALU.
- Owns the architectural HI/LO registers.
- Models multi-cycle mult/div latency with a busy counter.
- Drives the HI/LO read value into the E-stage result mux, which feeds the E/M pipeline register. Raises a stall request toward the decode stage.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- op  in  4  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
- start  in  1  E-stage instr is mult/multu/div/divu (and madd family if enabled); low when E is bubbled
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- md_use_D  in  1  D-stage instr is any MDU instr (op 1–8, plus 9–12 if enabled)
- busy  out  1  operation in flight
- stall_md  out  1  md_use_D & (start | busy)
- md_out  out  32  HI if op=7, LO if op=8, else 0 (combinational)
- HI  out  32  architectural HI
- LO  out  32  architectural LO

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, state IDLE. Reset mid-operation aborts; no HI/LO write.
- States: IDLE, BUSY.
- IDLE, start=1 on edge T:
  - latch a 64-bit result {hi_n, lo_n}, computed from A/B at T;
  - counter ← N (MULT_CYCLES or DIV_CYCLES); go BUSY.
- BUSY:
  - busy=1 during cycles T+1 … T+N; counter decrements each edge.
  - On the edge where counter=1: HI←hi_n, LO←lo_n, go IDLE.
  - New values are visible and busy=0 in cycle T+N+1.
- start while BUSY: ignored. Cannot occur architecturally because of stall_md.
- mthi/mtlo: write HI/LO ← A at the edge, only in IDLE with start=0. If issued in BUSY, the write is dropped and a simulation-only error is printed.
- mult: signed 32×32→64. multu: unsigned. HI=upper 32 bits, LO=lower 32 bits.
- div: LO=signed quotient truncated toward zero; HI=remainder, sign of dividend.
- divu: unsigned quotient and remainder.
- B=0 on div/divu: full latency still taken; HI/LO keep their old values.
- 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- stall_md is asserted in the start cycle itself, so a dependent mfhi/mflo/mult in D waits the full latency.
- md_out is purely combinational. It reflects HI/LO values committed up to the current cycle.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - ops 9 madd, 10 maddu, 11 msub, 12 msubu are accepted via start;
  - they use MULT_CYCLES latency;
  - at completion {HI,LO} ← {HI,LO} ± product, using the signed/unsigned product, with 64-bit wrap-around.
  - The accumulator base is the HI/LO value at the start edge.
- Undefined: ops 9–12 behave as op 0 (no effect, start ignored).

Decomposition:
- Package mdu_pkg:
  - op encoding localparams (MD_NONE … MD_MSUBU);
  - state encoding;
  - default cycle counts.
- One sub-module, mdu_arith: purely combinational. Takes op, A, B, HI, LO and produces the 64-bit result {hi_n, lo_n}, including div-by-zero hold and the madd family.
- mdu_e keeps the FSM, counter, HI/LO registers and stall logic.

Test Plan:
- mult: A=0xFFFFFFFE, B=3, start at T.
  - Expect busy=1 for T+1..T+5.
  - At T+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: same operands.
  - Expect HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div: A=-7 (0xFFFFFFF9), B=2.
  - After 10 busy cycles: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu: A=100, B=0, with HI/LO preloaded via mthi 0x11, mtlo 0x22.
  - 10 busy cycles, then HI=0x11, LO=0x22 unchanged.
- Interlocks:
  - start with md_use_D=1: stall_md=1 in the start cycle and for all busy cycles, then 0.
  - mthi during BUSY: HI unchanged; error message logged.
  - reset asserted at busy cycle 3: next cycle busy=0, HI=LO=0, no later write.
- Optional feature (MDU_MADD_EN defined): HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1.
  - Expect HI=1, LO=0 after 5 busy cycles.
  - With the macro undefined: op=10 with start leaves busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and default latencies for the E-stage multiply/divide unit
package mdu_pkg;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result for mult/div (and madd family when MDU_MADD_EN is defined)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res
);
  logic [63:0] w_sprod, w_uprod, w_hilo, w_base;
  logic [31:0] w_b_safe, w_uq, w_ur, w_abs_a, w_abs_b, w_mq, w_mr, w_sq, w_sr;
  logic        w_b0;
  assign w_hilo   = {i_hi, i_lo};
  assign w_sprod  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_uprod  = {32'b0, i_a} * {32'b0, i_b};
  assign w_b0     = i_b == 32'd0;
  // a zero divisor is replaced by 1 so the dividers never see x; the result is discarded anyway
  assign w_b_safe = w_b0 ? 32'd1 : i_b;
  assign w_uq     = i_a / w_b_safe;
  assign w_ur     = i_a % w_b_safe;
  // signed divide on magnitudes: 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0
  assign w_abs_a  = i_a[31] ? -i_a : i_a;
  assign w_abs_b  = w_b_safe[31] ? -w_b_safe : w_b_safe;
  assign w_mq     = w_abs_a / w_abs_b;
  assign w_mr     = w_abs_a % w_abs_b;
  assign w_sq     = (i_a[31] ^ i_b[31]) ? -w_mq : w_mq;
  assign w_sr     = i_a[31] ? -w_mr : w_mr;
  assign w_base   = (i_op == MD_MULT)  ? w_sprod :
                    (i_op == MD_MULTU) ? w_uprod :
                    (i_op == MD_DIV)   ? (w_b0 ? w_hilo : {w_sr, w_sq}) :
                    (i_op == MD_DIVU)  ? (w_b0 ? w_hilo : {w_ur, w_uq}) : w_hilo;
`ifdef MDU_MADD_EN
  logic [63:0] w_prod, w_acc;
  assign w_prod = (i_op == MD_MADD || i_op == MD_MSUB) ? w_sprod : w_uprod;
  assign w_acc  = (i_op == MD_MSUB || i_op == MD_MSUBU) ? w_hilo - w_prod : w_hilo + w_prod;
  assign o_res  = (i_op >= MD_MADD && i_op <= MD_MSUBU) ? w_acc : w_base;
`else
  assign o_res  = w_base;
`endif
endmodule

// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit owning HI/LO with modelled latency; MDU_MADD_EN enables madd/maddu/msub/msubu
module mdu_e
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] md_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_res, w_res;
  logic        w_accept, w_is_div;
  logic [CW-1:0] w_n;
  mdu_arith u_arith (
    .i_op  (op),
    .i_a   (A),
    .i_b   (B),
    .i_hi  (HI),
    .i_lo  (LO),
    .o_res (w_res)
  );
`ifdef MDU_MADD_EN
  assign w_accept = start && ((op >= MD_MULT && op <= MD_DIVU) || (op >= MD_MADD && op <= MD_MSUBU));
`else
  assign w_accept = start && op >= MD_MULT && op <= MD_DIVU;
`endif
  assign w_is_div = op == MD_DIV || op == MD_DIVU;
  assign w_n      = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  assign busy     = r_state == S_BUSY;
  assign stall_md = md_use_D & (start | busy);
  assign md_out   = (op == MD_MFHI) ? HI : (op == MD_MFLO) ? LO : 32'd0;
  // Latch the result at start, count down the latency, then commit HI/LO; moves only land while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_res   <= '0;
      HI      <= '0;
      LO      <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_res   <= w_res;
        r_cnt   <= w_n;
        r_state <= S_BUSY;
      end else if (!start && op == MD_MTHI) begin
        HI <= A;
      end else if (!start && op == MD_MTLO) begin
        LO <= A;
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        HI      <= r_res[63:32];
        LO      <= r_res[31:0];
        r_state <= S_IDLE;
      end
    end
  end
`ifndef SYNTHESIS
  // Report HI/LO moves that are dropped because an operation is still in flight
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_BUSY && (op == MD_MTHI || op == MD_MTLO))
      $warning("mdu_e: mthi/mtlo dropped while busy");
  end
`endif
endmodule

// File: tb/tb_mdu_e.sv
// tb_mdu_e: scoreboard-driven self-checking bench for mdu_e
module tb_mdu_e;
  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MFHI = 4'd7, OP_MFLO = 4'd8, OP_MADDU = 4'd10;
  localparam int MULT_N = 5, DIV_N = 10;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int n;} exp_t;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, md_use_D = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] A = '0, B = '0;
  logic        busy, stall_md;
  logic [31:0] md_out, HI, LO;
  exp_t        sb[$];
  int          n_checks = 0, n_fail = 0;
  mdu_e dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .start    (start),
    .A        (A),
    .B        (B),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .md_out   (md_out),
    .HI       (HI),
    .LO       (LO)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (o)
      OP_MULT:  begin q = x * y; return q; end
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV:   begin q = x / y; r = x % y; return {r[31:0], q[31:0]}; end
      default:  return {a % b, a / b};
    endcase
  endfunction
  task automatic expect_res(input logic [63:0] r, input int n);
    sb.push_back('{hi: r[63:32], lo: r[31:0], n: n});
  endtask
  task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic md);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1; md_use_D = md;
    #1;
    n_checks++;
    if (stall_md !== md) begin n_fail++; $display("FAIL stall_start: got %b want %b", stall_md, md); end
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
  endtask
  task automatic wait_done(input string name);
    exp_t e;
    int   cyc;
    e = sb.pop_front();
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      n_checks++;
      if (stall_md !== md_use_D) begin n_fail++; $display("FAIL %s_stall_busy: got %b want %b", name, stall_md, md_use_D); end
      cyc++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (cyc != e.n) begin n_fail++; $display("FAIL %s_cycles: got %0d want %0d", name, cyc, e.n); end
    n_checks++;
    if (HI !== e.hi) begin n_fail++; $display("FAIL %s_hi: got %h want %h", name, HI, e.hi); end
    n_checks++;
    if (LO !== e.lo) begin n_fail++; $display("FAIL %s_lo: got %h want %h", name, LO, e.lo); end
    n_checks++;
    if (stall_md !== 1'b0) begin n_fail++; $display("FAIL %s_stall_end: got %b want 0", name, stall_md); end
    md_use_D = 1'b0;
  endtask
  task automatic move(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk);
    op = o; A = v; start = 1'b0;
    @(posedge clk); #1;
    op = OP_NONE;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, stall_md, HI, LO} !== 66'd0) begin n_fail++; $display("FAIL reset: got busy=%b stall=%b hi=%h lo=%h want all 0", busy, stall_md, HI, LO); end
  endtask
  task automatic test_plan_ops;
    expect_res(64'hFFFFFFFF_FFFFFFFA, MULT_N); start_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0); wait_done("mult");
    expect_res(64'h00000002_FFFFFFFA, MULT_N); start_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0); wait_done("multu");
    expect_res(64'hFFFFFFFF_FFFFFFFD, DIV_N); start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0); wait_done("div");
    expect_res(64'h00000000_80000000, DIV_N); start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_done("div_ovf");
  endtask
  task automatic test_div_zero;
    move(OP_MTHI, 32'h11);
    move(OP_MTLO, 32'h22);
    n_checks++;
    if ({HI, LO} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL mthi_mtlo: got %h %h want 11 22", HI, LO); end
    expect_res({32'h11, 32'h22}, DIV_N); start_op(OP_DIVU, 32'd100, 32'd0, 1'b0); wait_done("divu_zero");
    expect_res({32'h11, 32'h22}, DIV_N); start_op(OP_DIV, 32'hFFFFFF00, 32'd0, 1'b0); wait_done("div_zero");
  endtask
  task automatic test_random;
    logic [3:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 4'(1 + (i % 4));
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = b >> 24;
      if (b == 0) b = 32'd7;
      expect_res(model(o, a, b), (o >= OP_DIV) ? DIV_N : MULT_N);
      start_op(o, a, b, 1'b0);
      wait_done("random");
    end
  endtask
  task automatic test_stall;
    expect_res(64'd42, MULT_N); start_op(OP_MULT, 32'd6, 32'd7, 1'b1); wait_done("stall");
  endtask
  task automatic test_mfhi_mflo;
    expect_res(64'h00000001_00000000, MULT_N); start_op(OP_MULTU, 32'h00010000, 32'h00010000, 1'b0); wait_done("mf_setup");
    @(negedge clk) op = OP_MFHI; #1;
    n_checks++;
    if (md_out !== 32'h1) begin n_fail++; $display("FAIL mfhi: got %h want 00000001", md_out); end
    op = OP_MFLO; #1;
    n_checks++;
    if (md_out !== 32'h0) begin n_fail++; $display("FAIL mflo: got %h want 00000000", md_out); end
    move(OP_MTLO, 32'hCAFE0001);
    @(negedge clk) op = OP_MFLO; #1;
    n_checks++;
    if (md_out !== 32'hCAFE0001) begin n_fail++; $display("FAIL mflo_moved: got %h want cafe0001", md_out); end
    op = OP_NONE; #1;
    n_checks++;
    if (md_out !== 32'h0) begin n_fail++; $display("FAIL md_out_none: got %h want 0", md_out); end
  endtask
  task automatic test_mthi_busy;
    move(OP_MTHI, 32'h55);
    expect_res(64'd42, MULT_N - 1);
    start_op(OP_MULT, 32'd7, 32'd6, 1'b0);
    op = OP_MTHI; A = 32'hDEADBEEF;
    @(posedge clk); #1;
    op = OP_NONE;
    n_checks++;
    if (HI !== 32'h55) begin n_fail++; $display("FAIL mthi_busy: got %h want 00000055", HI); end
    wait_done("mthi_busy");
  endtask
  task automatic test_back_to_back;
    expect_res(model(OP_MULT, 32'h12345678, 32'hFEDCBA98), MULT_N);
    start_op(OP_MULT, 32'h12345678, 32'hFEDCBA98, 1'b0); wait_done("b2b_first");
    expect_res(model(OP_DIVU, 32'hFFFFFFFF, 32'd10), DIV_N - 1);
    start_op(OP_DIVU, 32'hFFFFFFFF, 32'd10, 1'b0);
    op = OP_MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    op = OP_NONE; start = 1'b0;
    wait_done("b2b_ignored_start");
  endtask
  task automatic test_reset_mid;
    move(OP_MTHI, 32'h33);
    move(OP_MTLO, 32'h44);
    start_op(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({busy, HI, LO} !== 65'd0) begin n_fail++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0", busy, HI, LO); end
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, HI, LO} !== 65'd0) begin n_fail++; $display("FAIL reset_mid_late: got busy=%b hi=%h lo=%h want 0", busy, HI, LO); end
  endtask
  task automatic test_madd;
    move(OP_MTHI, 32'h0);
    move(OP_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    expect_res(64'h00000001_00000000, MULT_N); start_op(OP_MADDU, 32'd1, 32'd1, 1'b0); wait_done("maddu");
`else
    start_op(OP_MADDU, 32'd1, 32'd1, 1'b0);
    n_checks++;
    if ({busy, HI, LO} !== {1'b0, 32'h0, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL maddu_off: got busy=%b hi=%h lo=%h want 0 0 ffffffff", busy, HI, LO); end
`endif
  endtask
  initial begin
    test_reset;
    test_plan_ops;
    test_div_zero;
    test_random;
    test_stall;
    test_mfhi_mflo;
    test_mthi_busy;
    test_back_to_back;
    test_reset_mid;
    test_madd;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
